// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and constants for the MSI interrupt controller
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } msi_state_e;

    localparam int MAX_IRQ_SRC = 32;

    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set request at or after ptr_i, wrapping
module rr_pick
    import irq_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = src_width(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    always_comb begin
        int j;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            // modulo keeps the index legal even if ptr_i holds a value >= N
            j = (int'(ptr_i) + k) % N;
            if (!valid_o && req_i[j]) begin
                idx_o   = W'(j);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/msi_irq_ctrl.sv
// rtl/msi_irq_ctrl.sv - edge-captured multi-source interrupt to MSI request generator
module msi_irq_ctrl
    import irq_pkg::*;
#(
    parameter  int N_SRC   = 4,
    parameter  int HOLDOFF = 16,
    parameter  int REARM   = 1,
    localparam int SW      = src_width(N_SRC)
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [N_SRC-1:0] irq_i,
    input  logic             msi_enabled,
    input  logic             msi_grant,
    output logic             msi_request,
    output logic [SW-1:0]    msi_src,
    output logic [N_SRC-1:0] pending_o,
    output logic [7:0]       coalesced_cnt
);

    if (N_SRC < 1 || N_SRC > MAX_IRQ_SRC || HOLDOFF < 0 || HOLDOFF > 255) begin : g_bad_param
        $error("msi_irq_ctrl: parameter out of range");
    end

    msi_state_e       state_q, state_d;
    logic [N_SRC-1:0] irq_q, irq_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [SW-1:0]    src_q, src_d;
    logic [SW-1:0]    ptr_q, ptr_d;
    logic [7:0]       hold_q, hold_d;
    logic [7:0]       coal_q, coal_d;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] grant_hit;
    logic [N_SRC-1:0] clr;
    logic             grant_fire;
    logic [SW-1:0]    pick_idx;
    logic             pick_vld;

    rr_pick #(.N(N_SRC)) u_rr_pick (
        .req_i   (pending_q),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_vld)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            irq_q     <= '0;
            pending_q <= '0;
            src_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            coal_q    <= '0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_d;
            pending_q <= pending_d;
            src_q     <= src_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            coal_q    <= coal_d;
        end
    end

    // Pending capture and coalescing; a rise on the winner during its grant re-pends it
    always_comb begin
        int sum;
        irq_d      = irq_i;
        rise       = irq_i & ~irq_q;
        grant_fire = (state_q == REQ) && msi_grant;
        grant_hit  = '0;
        clr        = '0;
        sum        = int'(coal_q);
        for (int i = 0; i < N_SRC; i++) begin
            grant_hit[i] = grant_fire && (src_q == SW'(i));
            clr[i]       = grant_hit[i] && !((REARM != 0) && irq_i[i]);
            if (rise[i] && pending_q[i] && !grant_hit[i]) begin
                sum = sum + 1;
            end
        end
        pending_d = (pending_q & ~clr) | rise;
        coal_d    = (sum > 255) ? 8'd255 : 8'(sum);
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (msi_enabled && pick_vld) begin
                    src_d   = pick_idx;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (msi_grant) begin
                    ptr_d   = (src_q == SW'(N_SRC - 1)) ? '0 : src_q + 1'b1;
                    hold_d  = 8'(HOLDOFF);
                    state_d = (HOLDOFF == 0) ? IDLE : HOLD;
                end else if (!msi_enabled) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                hold_d = hold_q - 8'd1;
                if (hold_q <= 8'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        msi_request   = (state_q == REQ);
        msi_src       = src_q;
        pending_o     = pending_q;
        coalesced_cnt = coal_q;
    end

endmodule
